ms_timer_scheduler: RTL and testbench
=====================================

// Module: ms_timer_scheduler
// PURPOSE
//  Shares one 1 ms tick generator among NUM_CH independent millisecond countdown requesters.
//  Sits between the Braille trainer control FSMs and the LFSR 1 ms tick generator.
//  Holds the tick generator in reset while no channel is running, so a start from all-idle is phase-aligned.
//  Counts ticks per channel and returns a one-cycle done pulse when each requested duration expires.
// PARAMETERS
//  NUM_CH  4   number of requester channels
//  CNT_W   12  duration width in ms (max 4095 ms)
// PORTS
//  clk        in   1             system clock, all logic on posedge
//  rst        in   1             synchronous reset, active-low
//  start      in   NUM_CH        per-channel start request, level sampled each cycle
//  cancel     in   NUM_CH        per-channel abort
//  dur_ms     in   NUM_CH*CNT_W  duration for ch i at [i*CNT_W +: CNT_W], sampled with start[i]
//  tick_in    in   1             one-cycle pulse from 1 ms generator (its timeout)
//  tick_rst_n out  1             drives the generator's active-low rst; 0 holds it in INIT
//  busy       out  NUM_CH        channel i in RUN
//  done       out  NUM_CH        one-cycle pulse: channel i expired
//  rem_ms     out  NUM_CH*CNT_W  remaining ms per channel
//  all_idle   out  1             ~|busy
// BEHAVIOUR
//  Reset (rst==0 at posedge): busy=0, done=0, rem_ms=0, tick_rst_n=0, all_idle=1; all channels IDLE.
//  Per-channel FSM, states IDLE and RUN:
//  - IDLE & start[i] & dur!=0 -> RUN, rem=dur; busy[i]=1 the cycle after start is sampled.
//  - IDLE & start[i] & dur==0 -> stays IDLE; done[i]=1 the next cycle, no tick consumed.
//  - RUN & tick_in & rem==1 -> IDLE, rem=0, done[i]=1 that same next cycle (1-cycle latency after tick).
//  - RUN & tick_in & rem>1 -> rem=rem-1.
//  - RUN & cancel[i] (no start[i]) -> IDLE, rem=0, no done pulse.
//  - RUN & start[i] -> restart: rem=new dur (dur==0 gives done next cycle, IDLE).
//  Simultaneous events, per channel:
//  - start beats cancel.
//  - start beats tick; the tick is not counted.
//  - cancel beats tick, even at rem==1: no done.
//  done is a pulse only; it is never held. done[i] and busy[i] are never both 1.
//  Tick gating:
//  - tick_rst_n is registered: 1 in cycle N+1 iff any channel is RUN in cycle N+1.
//  - It rises together with the first busy bit and falls together with the last busy bit.
//  - A tick_in arriving while all channels are IDLE is ignored.
//  Accuracy:
//  - A start from all-idle restarts the generator, so elapsed time is exactly dur ms plus generator INIT cycles.
//  - A start while another channel runs counts dur ticks from the free-running generator; elapsed is in (dur-1, dur] ms.
//  Arithmetic: rem is unsigned CNT_W; it never decrements below 1 in RUN (no wrap).
//  Channels are fully independent; any number may run or expire in the same cycle.
//  rst mid-run: all channels abort immediately, no done, tick_rst_n=0 next cycle.
// TESTING
//  1. Reset, idle: tick_in pulsed -> busy=0, done=0, tick_rst_n stays 0.
//  2. ch0 start, dur=3, all idle:
//     - tick_rst_n=1 and busy[0]=1 next cycle.
//     - After 3 tick_in pulses, done[0]=1 for exactly 1 cycle.
//     - busy[0]=0 and tick_rst_n=0 the same cycle.
//  3. ch1 dur=0 -> done[1] pulse next cycle; busy[1] never set; tick_rst_n stays 0.
//  4. ch0 dur=5, ch2 dur=2 started two ticks later:
//     - done[2] on the 4th tick overall, done[0] on the 5th.
//     - tick_rst_n held 1 throughout.
//  5. ch3 dur=2, cancel[3] asserted with the 2nd tick -> no done[3], busy[3]=0, rem=0.
//  6. ch0 running, rem=4:
//     - start with dur=10 in the same cycle as tick_in and cancel -> rem_ms[ch0]=10, busy stays 1.
//     - Then rst=0 for 1 cycle -> all outputs return to reset values.

Source files
------------

// File: rtl/ms_timer_scheduler.sv
// ms_timer_scheduler
// Several millisecond countdown channels share one 1 ms tick generator.
// The generator is held in reset whenever no channel is counting, so the
// first tick after a start from all-idle arrives a full period later.
module ms_timer_scheduler #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       cancel,
  input  logic [NUM_CH*CNT_W-1:0] dur_ms,
  input  logic                    tick_in,
  output logic                    tick_rst_n,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done,
  output logic [NUM_CH*CNT_W-1:0] rem_ms,
  output logic                    all_idle
);

  // Per-channel state: busy bit is the RUN state, rem counts remaining ticks
  logic [NUM_CH-1:0] busy_reg, busy_next;
  logic [NUM_CH-1:0] done_reg, done_next;
  logic [CNT_W-1:0]  rem_reg  [NUM_CH];
  logic [CNT_W-1:0]  rem_next [NUM_CH];
  logic [CNT_W-1:0]  dur_arr  [NUM_CH];
  logic              tick_rst_n_reg;

  // Unpack the flat duration bus and pack the remaining-time bus
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign dur_arr[gi]                  = dur_ms[gi*CNT_W +: CNT_W];
      assign rem_ms[gi*CNT_W +: CNT_W]    = rem_reg[gi];
    end
  endgenerate

  // Next-state per channel; priority is start > cancel > tick
  always_comb begin
    busy_next = busy_reg;
    done_next = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rem_next[i] = rem_reg[i];
      if (start[i]) begin
        // A zero duration expires immediately without touching the tick stream
        if (dur_arr[i] != '0) begin
          busy_next[i] = 1'b1;
          rem_next[i]  = dur_arr[i];
        end else begin
          busy_next[i] = 1'b0;
          rem_next[i]  = '0;
          done_next[i] = 1'b1;
        end
      end else if (busy_reg[i] && cancel[i]) begin
        busy_next[i] = 1'b0;
        rem_next[i]  = '0;
      end else if (busy_reg[i] && tick_in) begin
        if (rem_reg[i] == CNT_W'(1)) begin
          busy_next[i] = 1'b0;
          rem_next[i]  = '0;
          done_next[i] = 1'b1;
        end else begin
          rem_next[i] = rem_reg[i] - CNT_W'(1);
        end
      end
    end
  end

  // State registers; the generator enable tracks next-cycle busy so it moves with busy
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_reg       <= '0;
      done_reg       <= '0;
      tick_rst_n_reg <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        rem_reg[i] <= '0;
      end
    end else begin
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      tick_rst_n_reg <= |busy_next;
      for (int i = 0; i < NUM_CH; i++) begin
        rem_reg[i] <= rem_next[i];
      end
    end
  end

  assign busy       = busy_reg;
  assign done       = done_reg;
  assign tick_rst_n = tick_rst_n_reg;
  assign all_idle   = ~|busy_reg;

endmodule

// File: tb/tb_ms_timer_scheduler.sv
// Testbench for ms_timer_scheduler: directed scenarios followed by random
// traffic, checked against a behavioural model through an expectation queue.
module tb_ms_timer_scheduler;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 12;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_CH-1:0]       start;
  logic [NUM_CH-1:0]       cancel;
  logic [NUM_CH*CNT_W-1:0] dur_ms;
  logic                    tick_in;
  logic                    tick_rst_n;
  logic [NUM_CH-1:0]       busy;
  logic [NUM_CH-1:0]       done;
  logic [NUM_CH*CNT_W-1:0] rem_ms;
  logic                    all_idle;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [NUM_CH-1:0]       busy;
    logic [NUM_CH-1:0]       done;
    logic [NUM_CH*CNT_W-1:0] rem;
    logic                    trn;
    logic                    idle;
    time                     t;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state: remaining ms per channel, 0 meaning not counting
  int m_left [NUM_CH];

  ms_timer_scheduler #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cancel     (cancel),
    .dur_ms     (dur_ms),
    .tick_in    (tick_in),
    .tick_rst_n (tick_rst_n),
    .busy       (busy),
    .done       (done),
    .rem_ms     (rem_ms),
    .all_idle   (all_idle)
  );

  always #5 clk = ~clk;

  function automatic logic [NUM_CH*CNT_W-1:0] pack(input int d0, input int d1,
                                                    input int d2, input int d3);
    logic [NUM_CH*CNT_W-1:0] v;
    v = '0;
    v[0*CNT_W +: CNT_W] = CNT_W'(d0);
    v[1*CNT_W +: CNT_W] = CNT_W'(d1);
    v[2*CNT_W +: CNT_W] = CNT_W'(d2);
    v[3*CNT_W +: CNT_W] = CNT_W'(d3);
    return v;
  endfunction

  // Apply one cycle of inputs and queue what the outputs must be after the next edge
  task automatic step(input logic r, input logic [NUM_CH-1:0] st,
                      input logic [NUM_CH-1:0] cn,
                      input logic [NUM_CH*CNT_W-1:0] d, input logic tk);
    exp_t e;
    int   du;
    @(posedge clk);
    #1;
    rst = r; start = st; cancel = cn; dur_ms = d; tick_in = tk;
    e.done = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      du = int'(d[i*CNT_W +: CNT_W]);
      if (!r) begin
        m_left[i] = 0;
      end else if (st[i]) begin
        // A new request replaces whatever the channel was doing
        m_left[i] = du;
        if (du == 0) e.done[i] = 1'b1;
      end else if (m_left[i] > 0 && cn[i]) begin
        m_left[i] = 0;
      end else if (m_left[i] > 0 && tk) begin
        m_left[i] = m_left[i] - 1;
        if (m_left[i] == 0) e.done[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      e.busy[i] = (m_left[i] > 0);
      e.rem[i*CNT_W +: CNT_W] = CNT_W'(m_left[i]);
    end
    e.trn  = (e.busy != '0);
    e.idle = (e.busy == '0);
    e.t    = $time;
    exp_q.push_back(e);
  endtask

  task automatic idle_cycles(input int n, input logic tk);
    for (int k = 0; k < n; k++) step(1'b1, '0, '0, '0, tk);
  endtask

  // Monitor: after each edge, compare outputs against the expectation queued before it
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      while (exp_q.size() > 0 && exp_q[0].t <= $time - 5) begin
        e = exp_q.pop_front();
        checks++;
        if (busy !== e.busy) begin
          errors++;
          $display("FAIL busy t=%0t got %b exp %b", $time, busy, e.busy);
        end
        checks++;
        if (done !== e.done) begin
          errors++;
          $display("FAIL done t=%0t got %b exp %b", $time, done, e.done);
        end
        checks++;
        if (rem_ms !== e.rem) begin
          errors++;
          $display("FAIL rem_ms t=%0t got %h exp %h", $time, rem_ms, e.rem);
        end
        checks++;
        if (tick_rst_n !== e.trn) begin
          errors++;
          $display("FAIL tick_rst_n t=%0t got %b exp %b", $time, tick_rst_n, e.trn);
        end
        checks++;
        if (all_idle !== e.idle) begin
          errors++;
          $display("FAIL all_idle t=%0t got %b exp %b", $time, all_idle, e.idle);
        end
        checks++;
        if ((done & busy) !== '0) begin
          errors++;
          $display("FAIL done_busy_overlap t=%0t got %b exp 0", $time, done & busy);
        end
      end
    end
  end

  // Stimulus: the scenarios from the block description, then random traffic
  initial begin
    logic [NUM_CH-1:0]       st, cn;
    logic [NUM_CH*CNT_W-1:0] d;
    logic                    r, tk;
    rst = 1'b0; start = '0; cancel = '0; dur_ms = '0; tick_in = 1'b0;
    for (int i = 0; i < NUM_CH; i++) m_left[i] = 0;

    // 1: reset, then ticks while idle are ignored
    step(1'b0, '0, '0, '0, 1'b0);
    step(1'b0, '0, '0, '0, 1'b1);
    idle_cycles(2, 1'b1);
    $display("scenario 1 idle ticks issued");

    // 2: ch0 dur=3 from all-idle
    step(1'b1, 4'b0001, '0, pack(3, 0, 0, 0), 1'b0);
    for (int k = 0; k < 3; k++) begin
      idle_cycles(1, 1'b0);
      idle_cycles(1, 1'b1);
    end
    idle_cycles(2, 1'b0);
    $display("scenario 2 ch0 dur=3 issued");

    // 3: ch1 dur=0 expires at once
    step(1'b1, 4'b0010, '0, pack(0, 0, 0, 0), 1'b0);
    idle_cycles(2, 1'b0);
    $display("scenario 3 ch1 dur=0 issued");

    // 4: ch0 dur=5, ch2 dur=2 after two ticks
    step(1'b1, 4'b0001, '0, pack(5, 0, 0, 0), 1'b0);
    idle_cycles(1, 1'b1);
    idle_cycles(1, 1'b1);
    step(1'b1, 4'b0100, '0, pack(0, 0, 2, 0), 1'b0);
    for (int k = 0; k < 3; k++) begin
      idle_cycles(1, 1'b0);
      idle_cycles(1, 1'b1);
    end
    idle_cycles(2, 1'b0);
    $display("scenario 4 ch0 dur=5 ch2 dur=2 issued");

    // 5: ch3 dur=2 cancelled together with its final tick
    step(1'b1, 4'b1000, '0, pack(0, 0, 0, 2), 1'b0);
    idle_cycles(1, 1'b1);
    step(1'b1, '0, 4'b1000, '0, 1'b1);
    idle_cycles(2, 1'b0);
    $display("scenario 5 cancel on last tick issued");

    // 6: restart beats tick and cancel, then reset mid-run
    step(1'b1, 4'b0001, '0, pack(6, 0, 0, 0), 1'b0);
    idle_cycles(2, 1'b1);
    step(1'b1, 4'b0001, 4'b0001, pack(10, 0, 0, 0), 1'b1);
    idle_cycles(1, 1'b1);
    step(1'b0, '0, '0, '0, 1'b0);
    idle_cycles(2, 1'b0);
    $display("scenario 6 restart and reset issued");

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0, 299) != 0);
      tk = ($urandom_range(0, 2) == 0);
      st = '0; cn = '0; d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        st[i] = ($urandom_range(0, 15) == 0);
        cn[i] = ($urandom_range(0, 24) == 0);
        case ($urandom_range(0, 7))
          0:       d[i*CNT_W +: CNT_W] = '0;
          1:       d[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(1, 4095));
          default: d[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(1, 8));
        endcase
      end
      step(r, st, cn, d, tk);
    end
    $display("random traffic issued");

    idle_cycles(2, 1'b0);
    @(posedge clk);
    #4;
    checks++;
    if (exp_q.size() > 1) begin
      errors++;
      $display("FAIL queue_drain got %0d pending exp <=1", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
